m1_portb_rd_sched: RTL

- Shares the read-only user port B of the 64 x 16 dual-port RAM m1 between g_num_req independent requesters.
- Each requester asks for a burst of consecutive words starting at a given address.
- The scheduler grants one requester at a time in round-robin order and sequences the RAM reads.
- Returned data goes to the owning requester.
- Sits between user-side consumers and the m1 port B pins: m1_adr_i, m1_r1_rd_i, m1_r1_dat_o.

---
 rtl/m1_sched_pkg.sv | 18 +
 rtl/m1_portb_rd_sched_if.sv | 30 +++
 rtl/m1_rr_pick.sv | 40 ++++
 rtl/m1_portb_rd_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/m1_sched_pkg.sv
// Shared constants, FSM state type and helpers for the m1 port-B read scheduler.
package m1_sched_pkg;
  localparam int c_num_req    = 4;
  localparam int c_addr_width = 6;
  localparam int c_data_width = 16;
  localparam int c_len_width  = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} t_state;

  // Highest set bit wins; callers only ever pass one-hot or zero.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/m1_portb_rd_sched_if.sv
// Requester and RAM-pin bundle for the port-B read scheduler.
interface m1_portb_rd_sched_if
  import m1_sched_pkg::*;
#(
  parameter int g_num_req    = c_num_req,
  parameter int g_addr_width = c_addr_width,
  parameter int g_data_width = c_data_width,
  parameter int g_len_width  = c_len_width
);
  logic [g_num_req-1:0]              req_i;
  logic [g_num_req*g_addr_width-1:0] adr_i;
  logic [g_num_req*g_len_width-1:0]  len_i;
  logic [g_num_req-1:0]              gnt_o;
  logic                              busy_o;
  logic [g_num_req-1:0]              rd_valid_o;
  logic                              rd_last_o;
  logic [g_data_width-1:0]           rd_dat_o;
  logic [g_addr_width-1:0]           ram_adr_o;
  logic                              ram_rd_o;
  logic [g_data_width-1:0]           ram_dat_i;

  modport slave (
    input  req_i, adr_i, len_i, ram_dat_i,
    output gnt_o, busy_o, rd_valid_o, rd_last_o, rd_dat_o, ram_adr_o, ram_rd_o
  );
  modport master (
    output req_i, adr_i, len_i, ram_dat_i,
    input  gnt_o, busy_o, rd_valid_o, rd_last_o, rd_dat_o, ram_adr_o, ram_rd_o
  );
endinterface

// File: rtl/m1_rr_pick.sv
// Combinational round-robin pick: first request strictly after i_last, wrapping.
module m1_rr_pick
  import m1_sched_pkg::*;
#(
  parameter int g_num_req = c_num_req,
  localparam int IW = (g_num_req > 1) ? $clog2(g_num_req) : 1
) (
  input  logic [g_num_req-1:0] i_req,
  input  logic [IW-1:0]        i_last,
  output logic [g_num_req-1:0] o_gnt,
  output logic [IW-1:0]        o_idx,
  output logic                 o_any
);
  logic [IW:0]          w_j;
  logic [IW-1:0]        w_jx;
  logic                 w_found;
  logic [g_num_req-1:0] w_gnt;
  logic [2:0]           w_idx3;

  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_j     = '0;
    w_jx    = '0;
    for (int i = 1; i <= g_num_req; i++) begin
      w_j = {1'b0, i_last} + (IW+1)'(i);
      if (w_j >= (IW+1)'(g_num_req)) w_j = w_j - (IW+1)'(g_num_req);
      w_jx = w_j[IW-1:0];
      if (!w_found && i_req[w_jx]) begin
        w_gnt[w_jx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign w_idx3 = onehot_to_idx(8'(w_gnt));
  assign o_gnt  = w_gnt;
  assign o_idx  = w_idx3[IW-1:0];
  assign o_any  = |i_req;
endmodule

// File: rtl/m1_portb_rd_sched.sv
// Round-robin burst read scheduler for m1 port B with a 2-stage return pipeline.
module m1_portb_rd_sched
  import m1_sched_pkg::*;
#(
  parameter int g_num_req    = c_num_req,
  parameter int g_addr_width = c_addr_width,
  parameter int g_data_width = c_data_width,
  parameter int g_len_width  = c_len_width
) (
  input logic               Clk,
  input logic               rst_n,
  m1_portb_rd_sched_if.slave bus
);
  localparam int IW = (g_num_req > 1) ? $clog2(g_num_req) : 1;

  t_state                  r_state, w_state_nxt;
  logic [IW-1:0]           r_ptr, w_ptr_nxt, w_pick_idx;
  logic [g_num_req-1:0]    r_gnt, w_gnt_nxt, w_pick_gnt;
  logic                    w_pick_any;
  logic [g_addr_width-1:0] r_adr, w_adr_nxt;
  logic [g_len_width-1:0]  r_cnt, w_cnt_nxt;
  logic                    r_rd, w_rd_nxt;
  logic [g_addr_width-1:0] w_adr_arr [g_num_req];
  logic [g_len_width-1:0]  w_len_arr [g_num_req];

  logic                    r_p1_vld, r_p1_last;
  logic [IW-1:0]           r_p1_own;
  logic [g_num_req-1:0]    r_rd_valid;
  logic                    r_rd_last;
  logic [g_data_width-1:0] r_rd_dat;

  for (genvar k = 0; k < g_num_req; k++) begin : g_unpack
    assign w_adr_arr[k] = bus.adr_i[k*g_addr_width +: g_addr_width];
    assign w_len_arr[k] = bus.len_i[k*g_len_width +: g_len_width];
  end

  m1_rr_pick #(.g_num_req(g_num_req)) u_pick (
    .i_req  (bus.req_i),
    .i_last (r_ptr),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Next-state values for every registered output; nothing reads in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_adr_nxt   = r_adr;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = 1'b0;
    case (r_state)
      IDLE: if (w_pick_any) begin
        w_state_nxt = BURST;
        w_ptr_nxt   = w_pick_idx;
        w_gnt_nxt   = w_pick_gnt;
        w_adr_nxt   = w_adr_arr[w_pick_idx];
        w_cnt_nxt   = w_len_arr[w_pick_idx];
        w_rd_nxt    = 1'b1;
      end
      BURST: if (r_cnt == '0) begin
        w_state_nxt = IDLE;
      end else begin
        w_adr_nxt = r_adr + g_addr_width'(1);
        w_cnt_nxt = r_cnt - g_len_width'(1);
        w_rd_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= IW'(g_num_req - 1);
      r_gnt      <= '0;
      r_adr      <= '0;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_p1_vld   <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_own   <= '0;
      r_rd_valid <= '0;
      r_rd_last  <= 1'b0;
      r_rd_dat   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_adr      <= w_adr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd       <= w_rd_nxt;
      // Owner and last flag travel with the read; RAM data lands a cycle later.
      r_p1_vld   <= r_rd;
      r_p1_last  <= r_rd && (r_cnt == '0);
      r_p1_own   <= r_ptr;
      r_rd_valid <= r_p1_vld ? (g_num_req'(1) << r_p1_own) : '0;
      r_rd_last  <= r_p1_vld && r_p1_last;
      if (r_p1_vld) r_rd_dat <= bus.ram_dat_i;
    end
  end

  assign bus.gnt_o      = r_gnt;
  assign bus.busy_o     = (r_state == BURST);
  assign bus.ram_rd_o   = r_rd;
  assign bus.ram_adr_o  = r_adr;
  assign bus.rd_valid_o = r_rd_valid;
  assign bus.rd_last_o  = r_rd_last;
  assign bus.rd_dat_o   = r_rd_dat;
endmodule
